// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the NTT controller slice.
package ntt_pkg;

    localparam int N                = 256;
    localparam int LOG2N            = 8;
    localparam int Q_KYBER          = 3329;
    localparam int Q_DILITHIUM      = 8380417;
    localparam int LAYERS_KYBER     = 7;
    localparam int LAYERS_DILITHIUM = 8;

    localparam logic MODE_INV  = 1'b1;
    localparam logic RED_KYBER = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } ntt_state_e;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address and twiddle index generator.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [2:0] layer,
    input  logic [6:0] bf,
    input  logic       mode,
    input  logic       sel_red,
    output logic [7:0] addr_a,
    output logic [7:0] addr_b,
    output logic [7:0] tw_addr
);

    logic [2:0] m;
    logic [3:0] m_plus1;
    logic [7:0] len;
    logic [6:0] g;
    logic [8:0] base;
    logic [8:0] k_full;

    // Kyber skips len=1, so its inverse layers start one step higher.
    always_comb begin
        m       = (mode == MODE_INV) ? (layer + {2'b00, sel_red}) : (3'd7 - layer);
        m_plus1 = {1'b0, m} + 4'd1;
        len     = 8'd1 << m;
        g       = bf >> m;
        base    = 9'd128 >> m;
        addr_a  = ({1'b0, g} << m_plus1) | ({1'b0, bf} & (len - 8'd1));
        addr_b  = addr_a + len;
        k_full  = (mode == MODE_INV) ? ((base << 1) - 9'd1 - {2'b00, g})
                                     : (base + {2'b00, g});
        tw_addr = k_full[7:0];
    end

endmodule

// File: rtl/ntt_ctrl.sv
// NTT layer/butterfly sequencer: issues coefficient-pair reads one per cycle
// and replays them as write-backs through an LAT-deep delay line.
module ntt_ctrl #(
    parameter int N   = 256,
    parameter int LAT = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       mode_i,
    input  logic       sel_red_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       rd_en_o,
    output logic [7:0] rd_addr_a_o,
    output logic [7:0] rd_addr_b_o,
    output logic [7:0] tw_addr_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_a_o,
    output logic [7:0] wr_addr_b_o,
    output logic       sel_butterfly_o,
    output logic       sel_red_o
);
    import ntt_pkg::*;

    localparam logic [6:0] BF_LAST    = 7'(N / 2 - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(LAT - 1);

    ntt_state_e state_q, state_d;
    logic [2:0] layer_q, layer_d;
    logic [6:0] bf_q, bf_d;
    logic [2:0] drain_q, drain_d;
    logic       mode_q, mode_d;
    logic       red_q, red_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] last_layer;

    logic [7:0] gen_a, gen_b, gen_k;
    logic       rd_en_q;
    logic [7:0] rd_a_q, rd_b_q, tw_q;
    logic [16:0] dly_q [LAT];

    ntt_addr_gen u_addr_gen (
        .layer   (layer_q),
        .bf      (bf_q),
        .mode    (mode_q),
        .sel_red (red_q),
        .addr_a  (gen_a),
        .addr_b  (gen_b),
        .tw_addr (gen_k)
    );

    assign last_layer = (red_q == RED_KYBER) ? 3'(LAYERS_KYBER - 1) : 3'(LAYERS_DILITHIUM - 1);

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        bf_d    = bf_q;
        drain_d = drain_q;
        mode_d  = mode_q;
        red_d   = red_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mode_d  = mode_i;
                    red_d   = sel_red_i;
                    layer_d = 3'd0;
                    bf_d    = 7'd0;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bf_d = bf_q + 7'd1;
                if (bf_q == BF_LAST) begin
                    drain_d = 3'd0;
                    state_d = DRAIN;
                end
            end
            // Hold off the next layer until every write of this one has retired.
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    if (layer_q == last_layer) begin
                        state_d = FINISH;
                    end else begin
                        layer_d = layer_q + 3'd1;
                        bf_d    = 7'd0;
                        state_d = ISSUE;
                    end
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            layer_q <= 3'd0;
            bf_q    <= 7'd0;
            drain_q <= 3'd0;
            mode_q  <= 1'b0;
            red_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= 8'd0;
            rd_b_q  <= 8'd0;
            tw_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            bf_q    <= bf_d;
            drain_q <= drain_d;
            mode_q  <= mode_d;
            red_q   <= red_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= (state_q == ISSUE);
            rd_a_q  <= gen_a;
            rd_b_q  <= gen_b;
            tw_q    <= gen_k;
        end
    end

    // Clearing the delay line on reset drops any in-flight write-backs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LAT; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= {rd_en_q, rd_a_q, rd_b_q};
            for (int i = 1; i < LAT; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign {wr_en_o, wr_addr_a_o, wr_addr_b_o} = dly_q[LAT-1];

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign rd_en_o         = rd_en_q;
    assign rd_addr_a_o     = rd_a_q;
    assign rd_addr_b_o     = rd_b_q;
    assign tw_addr_o       = tw_q;
    assign sel_butterfly_o = mode_q;
    assign sel_red_o       = red_q;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Scoreboard bench for ntt_ctrl: a reference NTT loop nest predicts every
// read/write pair, twiddle index and cycle; a monitor pops and compares them.
module tb_ntt_ctrl;

    localparam int LAT = 2;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] k;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       mode_i;
    logic       sel_red_i;
    logic       busy_o, done_o, rd_en_o, wr_en_o;
    logic [7:0] rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o;
    logic       sel_butterfly_o, sel_red_o;

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    int         hazards = 0;
    logic [255:0] pend = '0;
    exp_t       rd_q[$];
    exp_t       wr_q[$];
    exp_t       mon_r, mon_w;

    ntt_ctrl #(.N(256), .LAT(LAT)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .mode_i          (mode_i),
        .sel_red_i       (sel_red_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .rd_en_o         (rd_en_o),
        .rd_addr_a_o     (rd_addr_a_o),
        .rd_addr_b_o     (rd_addr_b_o),
        .tw_addr_o       (tw_addr_o),
        .wr_en_o         (wr_en_o),
        .wr_addr_a_o     (wr_addr_a_o),
        .wr_addr_b_o     (wr_addr_b_o),
        .sel_butterfly_o (sel_butterfly_o),
        .sel_red_o       (sel_red_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference loop nest in the usual software NTT order; k runs continuously across layers.
    task automatic pushExpected(input logic inv, input logic kyber, input int s_cyc);
        int   layers, len, k, t;
        exp_t e;
        layers = kyber ? 7 : 8;
        len    = inv ? (kyber ? 2 : 1) : 128;
        k      = inv ? (kyber ? 128 : 256) : 0;
        for (int lay = 0; lay < layers; lay++) begin
            t = 0;
            for (int st = 0; st < 256; st += 2 * len) begin
                k = inv ? k - 1 : k + 1;
                for (int j = st; j < st + len; j++) begin
                    e.a   = 8'(j);
                    e.b   = 8'(j + len);
                    e.k   = 8'(k);
                    e.cyc = s_cyc + 1 + lay * (128 + LAT) + t;
                    rd_q.push_back(e);
                    e.cyc = e.cyc + LAT;
                    wr_q.push_back(e);
                    t++;
                end
            end
            len = inv ? len * 2 : len / 2;
        end
    endtask

    task automatic waitDone(input int budget, output int d_cyc);
        d_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                d_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic inv, input logic kyber, input bit interfere);
        int s_cyc, d_cyc, layers;
        layers   = kyber ? 7 : 8;
        rd_cnt   = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        hazards  = 0;
        @(posedge clk); #1;
        mode_i    = inv;
        sel_red_i = kyber;
        start_i   = 1'b1;
        s_cyc     = cyc + 1;
        pushExpected(inv, kyber, s_cyc);
        @(posedge clk); #1;
        start_i   = 1'b0;
        mode_i    = ~inv;
        sel_red_i = ~kyber;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("busy_high", 32'(busy_o), 1);
        checkOutput("sel_latched", {sel_butterfly_o, sel_red_o}, {inv, kyber});
        if (interfere) begin
            repeat (40) @(posedge clk);
            #1 start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            checkOutput("sel_after_restart", {sel_butterfly_o, sel_red_o}, {inv, kyber});
        end
        waitDone(1400, d_cyc);
        checkOutput("done_latency", d_cyc - s_cyc, layers * (128 + LAT) + 1);
        checkOutput("rd_count", rd_cnt, kyber ? 896 : 1024);
        checkOutput("wr_count", wr_cnt, kyber ? 896 : 1024);
        checkOutput("rd_queue_left", rd_q.size(), 0);
        checkOutput("wr_queue_left", wr_q.size(), 0);
        checkOutput("hazards", hazards, 0);
        @(negedge clk);
        checkOutput("done_single", {done_o, busy_o}, 2'b00);
        $display("[TB] run inv=%0b kyber=%0b interfere=%0b finished", inv, kyber, interfere);
    endtask

    always @(negedge clk) begin
        if (rd_en_o === 1'b1 && wr_en_o === 1'b1) begin
            if (rd_addr_a_o == wr_addr_a_o || rd_addr_a_o == wr_addr_b_o ||
                rd_addr_b_o == wr_addr_a_o || rd_addr_b_o == wr_addr_b_o)
                hazards++;
        end
        if (wr_en_o === 1'b1) begin
            wr_cnt++;
            checkOutput("wr_expected_pending", 32'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) begin
                mon_w = wr_q.pop_front();
                checkOutput("wr_pair", {wr_addr_a_o, wr_addr_b_o}, {mon_w.a, mon_w.b});
                checkOutput("wr_cycle", cyc, mon_w.cyc);
            end
            pend[wr_addr_a_o] = 1'b0;
            pend[wr_addr_b_o] = 1'b0;
        end
        if (rd_en_o === 1'b1) begin
            rd_cnt++;
            checkOutput("rd_expected_pending", 32'(rd_q.size() != 0), 1);
            if (rd_q.size() != 0) begin
                mon_r = rd_q.pop_front();
                checkOutput("rd_pair_tw", {rd_addr_a_o, rd_addr_b_o, tw_addr_o},
                            {mon_r.a, mon_r.b, mon_r.k});
                checkOutput("rd_cycle", cyc, mon_r.cyc);
            end
            if (pend[rd_addr_a_o] || pend[rd_addr_b_o]) hazards++;
            pend[rd_addr_a_o] = 1'b1;
            pend[rd_addr_b_o] = 1'b1;
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            checkOutput("busy_in_done", 32'(busy_o), 0);
        end
    end

    initial begin
        int s_cyc;
        rst_i     = 1'b1;
        start_i   = 1'b1;
        mode_i    = 1'b1;
        sel_red_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_strobes", {busy_o, done_o, rd_en_o, wr_en_o, sel_butterfly_o, sel_red_o}, 0);
        checkOutput("reset_rd_addrs", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, 0);
        checkOutput("reset_wr_addrs", {wr_addr_a_o, wr_addr_b_o}, 0);
        @(posedge clk); #1;
        rst_i     = 1'b0;
        start_i   = 1'b0;
        mode_i    = 1'b0;
        sel_red_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("start_during_reset_ignored", {busy_o, rd_en_o, sel_butterfly_o, sel_red_o}, 0);

        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Abort a forward Dilithium transform partway through layer 2.
        @(posedge clk); #1;
        mode_i    = 1'b0;
        sel_red_i = 1'b0;
        start_i   = 1'b1;
        s_cyc     = cyc + 1;
        pushExpected(1'b0, 1'b0, s_cyc);
        @(posedge clk); #1;
        start_i = 1'b0;
        while (cyc < s_cyc + 300) @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_strobes", {rd_en_o, wr_en_o, busy_o, done_o}, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        rd_q.delete();
        wr_q.delete();
        pend     = '0;
        wr_cnt   = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        repeat (30) @(negedge clk);
        checkOutput("abort_wr_pulses", wr_cnt, 0);
        checkOutput("abort_rd_pulses", rd_cnt, 0);
        checkOutput("abort_done", done_cnt, 0);
        checkOutput("abort_busy", 32'(busy_o), 0);

        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ntt_ctrl.md
NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 Parameter N, default 256, number of polynomial coefficients; SHALL be fixed at 256.
REQ-002 Parameter LAT, default 2, cycles from read issue to write-back (1 memory read + 1 result register); range 1..4.
REQ-003 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 start_i  input  1  one-cycle request to begin a transform.
REQ-006 mode_i  input  1  0 = forward NTT (Cooley-Tukey), 1 = inverse NTT (Gentleman-Sande); sampled with start_i.
REQ-007 sel_red_i  input  1  0 = Dilithium (q=8380417, 8 layers), 1 = Kyber (q=3329, 7 layers); sampled with start_i.
REQ-008 busy_o  output  1  high from the accepted start until done_o.
REQ-009 done_o  output  1  one-cycle pulse after the final write-back.
REQ-010 rd_en_o  output  1  coefficient-pair read strobe.
REQ-011 rd_addr_a_o, rd_addr_b_o  output  8 each  read addresses of pair (j, j+len).
REQ-012 tw_addr_o  output  8  twiddle ROM index k, aligned with rd_en_o.
REQ-013 wr_en_o  output  1  write-back strobe, rd_en_o delayed LAT cycles.
REQ-014 wr_addr_a_o, wr_addr_b_o  output  8 each  rd addresses delayed LAT cycles.
REQ-015 sel_butterfly_o, sel_red_o  output  1 each  latched mode_i / sel_red_i, stable while busy_o.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, DRAIN, FINISH.
REQ-017 IDLE: start_i=1 -> latch mode/sel_red, layer counter 0, butterfly counter bf 0, go to ISSUE; start_i while not IDLE SHALL be ignored.
REQ-018 ISSUE: one butterfly per cycle, rd_en_o=1, bf 0..127; after bf=127 go to DRAIN.
REQ-019 DRAIN: rd_en_o=0 for exactly LAT cycles so all writes of the layer retire before the next layer reads; then ISSUE of next layer, or FINISH after last layer.
REQ-020 FINISH: done_o=1 for one cycle, busy_o=0 in that cycle, return to IDLE.
REQ-021 Layers: forward len = 128,64,...,1 (Dilithium) or ...,2 (Kyber); inverse len = 1,2,...,128 (Dilithium) or 2,...,128 (Kyber).
REQ-022 With m=log2(len): group g = bf>>m; j = (g<<(m+1)) | (bf & (len-1)); rd_addr_a_o=j; rd_addr_b_o=j+len.
REQ-023 Twiddle: forward k = 128/len + g; inverse k = 2*(128/len) - 1 - g; ROM encodes inverse twiddle sign.
REQ-024 Total ISSUE cycles: 1024 Dilithium, 896 Kyber; start-to-done latency = layers*(128+LAT)+1 cycles.
REQ-025 Outputs rd_* and tw_addr_o SHALL be registered; wr_* SHALL come from an LAT-deep shift register; rd_en_o and wr_en_o SHALL never address the same coefficient in the same cycle.
REQ-026 Address values when the associated enable is 0 are don't-care but SHALL not be X after reset.

Reset
REQ-027 rst_i=1 SHALL force IDLE; busy_o, done_o, rd_en_o, wr_en_o, sel_butterfly_o, sel_red_o = 0; all addresses = 0; shift register cleared.
REQ-028 Reset mid-transform SHALL abort with no further wr_en_o pulses and no done_o.
REQ-029 start_i coincident with rst_i SHALL be ignored.

Structure
REQ-030 Shared package ntt_pkg SHALL hold N, LOG2N, Q_KYBER=3329, Q_DILITHIUM=8380417, layer counts (7, 8) and the FSM state enum.
REQ-031 One sub-module ntt_addr_gen (combinational j/j+len/k from layer, bf, mode) is natural; FSM and delay line stay in ntt_ctrl.

Verification
REQ-032 Forward Dilithium, LAT=2: first ISSUE cycle a=0,b=128,k=1; layer-2 first g=1 pair (128,192),k=3; done_o exactly 1041 cycles after start.
REQ-033 Inverse Kyber: first pair (0,2),k=127; pair at bf=2 is (4,6),k=126; last pair (127,255),k=1; 7 layers, done after 911 cycles.
REQ-034 Golden model: drive ntt_ctrl+butterfly+RAM with x=[1,0,...,0], forward then inverse (Dilithium) -> coefficients equal 256*x mod q before n^-1 scaling.
REQ-035 Hazard check: every wr_addr of layer L retires before any rd of layer L+1 reads it; count of wr_en_o pulses = 1024/896.
REQ-036 Assert rst_i at cycle 300 of a transform -> all strobes 0 next cycle, no done_o; fresh start completes normally.
REQ-037 start_i pulsed while busy_o and with mode_i toggled -> ignored, sel_butterfly_o unchanged, timing identical to REQ-032.
